// File: rtl/eq2_mon_pkg.sv
// ---------------------------------------------------------------------------
// eq2_mon_pkg
// Shared types and constants for the eq2 match monitor.
//   mon_state_t : lock FSM state encoding
//   EVT_LOCK    : evt_code value for a lock-gained event
//   EVT_LOSS    : evt_code value for a lock-lost event
// Optional feature macro: EQ2_MON_HYST_EN (adds the LOCKED_WARN state).
// ---------------------------------------------------------------------------
package eq2_mon_pkg;

    typedef enum logic [1:0] {
        ST_HUNT        = 2'd0,
`ifdef EQ2_MON_HYST_EN
        ST_LOCKED      = 2'd1,
        ST_LOCKED_WARN = 2'd2
`else
        ST_LOCKED      = 2'd1
`endif
    } mon_state_t;

    localparam logic EVT_LOCK = 1'b1;
    localparam logic EVT_LOSS = 1'b0;

endpackage : eq2_mon_pkg

// File: rtl/eq2.sv
// ---------------------------------------------------------------------------
// eq2
// 2-bit equality comparator.
//   a    : first operand (2 bits)
//   b    : second operand (2 bits)
//   aeqb : 1 when a == b on both bits
// ---------------------------------------------------------------------------
module eq2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       aeqb
);

    assign aeqb = (a == b);

endmodule : eq2

// File: rtl/eq2_match_monitor.sv
// ---------------------------------------------------------------------------
// eq2_match_monitor
// Counts matching / mismatching 2-bit sample pairs, tracks the current run of
// consecutive matches and declares lock once the run reaches RUN_LEN. Every
// lock change raises an event that must be acknowledged before more samples
// are accepted.
//
// Parameters
//   RUN_LEN : consecutive matches needed for lock (1..15)
//   CNT_W   : width of match_cnt / miss_cnt
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   a, b      : sample pair
//   in_valid  : sample present
//   in_ready  : monitor accepts a sample this cycle (registered)
//   clr       : synchronous clear of counters, run and FSM
//   match_cnt : accepted samples with a==b (saturating)
//   miss_cnt  : accepted samples with a!=b (saturating)
//   run_cnt   : current match run (saturates at RUN_LEN)
//   lock      : FSM is locked
//   evt_valid : lock-change event pending
//   evt_code  : 1 = lock gained, 0 = lock lost
//   evt_ready : consumer takes the event
// Optional feature macro: EQ2_MON_HYST_EN -- a single miss while locked only
// moves to LOCKED_WARN; a second consecutive miss drops lock.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// ST_HUNT        | not locked, building a run of matches
// ST_LOCKED      | locked
// ST_LOCKED_WARN | locked, one miss seen (hysteresis build only)
// ---------------------------------------------------------------------------
module eq2_match_monitor
    import eq2_mon_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [3:0]       run_cnt,
    output logic             lock,
    output logic             evt_valid,
    output logic             evt_code,
    input  logic             evt_ready
);

    localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic             lock_q, lock_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_code_q, evt_code_d;
    logic             in_ready_q;
    logic             aeqb;
    logic             accept;

    eq2 u_eq2 (
        .a    (a),
        .b    (b),
        .aeqb (aeqb)
    );

    // in_ready_q is low whenever an event is pending, so accept never
    // coincides with evt_valid_q.
    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        run_cnt_d   = run_cnt_q;
        evt_valid_d = evt_valid_q & ~evt_ready;
        evt_code_d  = evt_code_q;

        if (clr) begin
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            run_cnt_d   = '0;
            evt_valid_d = 1'b0;
        end else if (accept) begin
            if (aeqb) begin
                if (match_cnt_q != {CNT_W{1'b1}}) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                end
                if (run_cnt_q < RUN_LEN_C) begin
                    run_cnt_d = run_cnt_q + 4'd1;
                end
                case (state_q)
                    ST_HUNT: begin
                        if (run_cnt_d == RUN_LEN_C) begin
                            state_d     = ST_LOCKED;
                            evt_valid_d = 1'b1;
                            evt_code_d  = EVT_LOCK;
                        end
                    end
`ifdef EQ2_MON_HYST_EN
                    ST_LOCKED_WARN: state_d = ST_LOCKED;
`endif
                    default: ;
                endcase
            end else begin
                if (miss_cnt_q != {CNT_W{1'b1}}) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
                run_cnt_d = '0;
                case (state_q)
                    ST_LOCKED: begin
`ifdef EQ2_MON_HYST_EN
                        state_d     = ST_LOCKED_WARN;
`else
                        state_d     = ST_HUNT;
                        evt_valid_d = 1'b1;
                        evt_code_d  = EVT_LOSS;
`endif
                    end
`ifdef EQ2_MON_HYST_EN
                    ST_LOCKED_WARN: begin
                        state_d     = ST_HUNT;
                        evt_valid_d = 1'b1;
                        evt_code_d  = EVT_LOSS;
                    end
`endif
                    default: ;
                endcase
            end
        end

        lock_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            run_cnt_q   <= '0;
            lock_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            run_cnt_q   <= run_cnt_d;
            lock_q      <= lock_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            in_ready_q  <= ~evt_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign match_cnt = match_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign run_cnt   = run_cnt_q;
    assign lock      = lock_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;

endmodule : eq2_match_monitor

// File: tb/tb_eq2_match_monitor.sv
// ---------------------------------------------------------------------------
// tb_eq2_match_monitor
// Directed bench for eq2_match_monitor. dut0 uses the defaults (RUN_LEN=4,
// CNT_W=16); dut1 uses RUN_LEN=1, CNT_W=2 for single-match lock and counter
// saturation. Expected values follow EQ2_MON_HYST_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_eq2_match_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [1:0]  a0 = '0, b0 = '0;
    logic        v0 = 1'b0, clr0 = 1'b0, er0 = 1'b0;
    logic        rdy0, lock0, ev0, ec0;
    logic [15:0] mc0, xc0;
    logic [3:0]  rc0;

    logic [1:0]  a1 = '0, b1 = '0;
    logic        v1 = 1'b0, clr1 = 1'b0, er1 = 1'b0;
    logic        rdy1, lock1, ev1, ec1;
    logic [1:0]  mc1, xc1;
    logic [3:0]  rc1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eq2_match_monitor #(.RUN_LEN(4), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst_n), .a(a0), .b(b0), .in_valid(v0),
        .in_ready(rdy0), .clr(clr0), .match_cnt(mc0), .miss_cnt(xc0),
        .run_cnt(rc0), .lock(lock0), .evt_valid(ev0), .evt_code(ec0),
        .evt_ready(er0)
    );

    eq2_match_monitor #(.RUN_LEN(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .in_ready(rdy1), .clr(clr1), .match_cnt(mc1), .miss_cnt(xc1),
        .run_cnt(rc1), .lock(lock1), .evt_valid(ev1), .evt_code(ec1),
        .evt_ready(er1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one cycle on dut0: drive at negedge, sample 1 time unit after posedge
    task automatic cyc0(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic er, input logic c);
        @(negedge clk);
        v0 = v; a0 = a; b0 = b; er0 = er; clr0 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic er);
        @(negedge clk);
        v1 = v; a1 = a; b1 = b; er1 = er;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_mc"},   32'(mc0), 0);
        check({tag, "_xc"},   32'(xc0), 0);
        check({tag, "_rc"},   32'(rc0), 0);
        check({tag, "_lock"}, 32'(lock0), 0);
        check({tag, "_ev"},   32'(ev0), 0);
        check({tag, "_ec"},   32'(ec0), 0);
        check({tag, "_rdy"},  32'(rdy0), 0);
    endtask

    initial begin
        // reset state before any clock edge
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 32'(rdy0), 1);

        // four matches -> lock gained
        cyc0(1, 2'b01, 2'b01, 0, 0);
        cyc0(1, 2'b01, 2'b01, 0, 0);
        cyc0(1, 2'b01, 2'b01, 0, 0);
        check("run3", 32'(rc0), 3);
        check("nolock3", 32'(lock0), 0);
        cyc0(1, 2'b01, 2'b01, 0, 0);
        check("lock4", 32'(lock0), 1);
        check("ev4", 32'(ev0), 1);
        check("ec4", 32'(ec0), 1);
        check("mc4", 32'(mc0), 4);
        check("run4", 32'(rc0), 4);
        check("rdy_evt", 32'(rdy0), 0);

        // event pending three cycles: nothing accepted
        for (int i = 0; i < 3; i++) begin
            cyc0(1, 2'b01, 2'b01, 0, 0);
            check("hold_mc", 32'(mc0), 4);
            check("hold_rdy", 32'(rdy0), 0);
            check("hold_ev", 32'(ev0), 1);
            check("hold_ec", 32'(ec0), 1);
        end

        // acknowledge
        cyc0(0, 2'b00, 2'b00, 1, 0);
        check("ack_ev", 32'(ev0), 0);
        check("ack_rdy", 32'(rdy0), 1);

        // one miss while locked
        cyc0(1, 2'b11, 2'b01, 0, 0);
        check("miss1_xc", 32'(xc0), 1);
        check("miss1_rc", 32'(rc0), 0);
`ifdef EQ2_MON_HYST_EN
        check("miss1_lock", 32'(lock0), 1);
        check("miss1_ev", 32'(ev0), 0);
        cyc0(1, 2'b11, 2'b01, 0, 0);
        check("miss2_xc", 32'(xc0), 2);
        check("miss2_lock", 32'(lock0), 0);
        check("miss2_ev", 32'(ev0), 1);
        check("miss2_ec", 32'(ec0), 0);
`else
        check("miss1_lock", 32'(lock0), 0);
        check("miss1_ev", 32'(ev0), 1);
        check("miss1_ec", 32'(ec0), 0);
`endif
        cyc0(0, 2'b00, 2'b00, 1, 0);
        check("ack2_ev", 32'(ev0), 0);

        // build run of 3, then clr alongside an accepted match
        cyc0(1, 2'b10, 2'b10, 0, 0);
        cyc0(1, 2'b00, 2'b00, 0, 0);
        cyc0(1, 2'b11, 2'b11, 0, 0);
        check("pre_clr_rc", 32'(rc0), 3);
        check("pre_clr_mc", 32'(mc0), 7);
        cyc0(1, 2'b11, 2'b11, 0, 1);
        check("clr_mc", 32'(mc0), 0);
        check("clr_xc", 32'(xc0), 0);
        check("clr_rc", 32'(rc0), 0);
        check("clr_lock", 32'(lock0), 0);
        check("clr_rdy", 32'(rdy0), 1);

        // run to 2, then on to lock with the event pending, then async reset
        cyc0(1, 2'b01, 2'b01, 0, 0);
        cyc0(1, 2'b10, 2'b10, 0, 0);
        check("run2", 32'(rc0), 2);
        cyc0(1, 2'b01, 2'b01, 0, 0);
        cyc0(1, 2'b01, 2'b01, 0, 0);
        check("relock_ev", 32'(ev0), 1);
        check("relock_lock", 32'(lock0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        v0 = 1'b0; er0 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy", 32'(rdy0), 1);
        check("post_rst_ev", 32'(ev0), 0);

        // dut1: RUN_LEN=1 single-match lock
        cyc1(1, 2'b10, 2'b10, 0);
        check("d1_lock", 32'(lock1), 1);
        check("d1_ev", 32'(ev1), 1);
        check("d1_ec", 32'(ec1), 1);
        check("d1_rc", 32'(rc1), 1);
        // misses with events acknowledged; at least 5 get accepted
        for (int i = 0; i < 12; i++) begin
            cyc1(1, 2'b00, 2'b11, 1);
        end
        check("d1_xc_sat", 32'(xc1), 3);
        check("d1_mc", 32'(mc1), 1);
        check("d1_unlock", 32'(lock1), 0);
        cyc1(1, 2'b00, 2'b11, 1);
        check("d1_xc_hold", 32'(xc1), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_eq2_match_monitor

// File: doc/eq2_match_monitor.md
EQ2_MATCH_MONITOR -- requirements
Module: eq2_match_monitor

Interface
REQ-001 Parameter RUN_LEN, default 4: consecutive accepted matches needed to declare lock; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the match and miss counters.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a  input  2  first operand of the sample pair.
REQ-006 b  input  2  second operand of the sample pair.
REQ-007 in_valid  input  1  sample pair present on a/b.
REQ-008 in_ready  output  1  monitor can accept a sample this cycle.
REQ-009 clr  input  1  synchronous clear of counters, run and FSM.
REQ-010 match_cnt  output  CNT_W  accepted samples with a==b.
REQ-011 miss_cnt  output  CNT_W  accepted samples with a!=b.
REQ-012 run_cnt  output  4  current consecutive-match run, saturating at RUN_LEN.
REQ-013 lock  output  1  FSM is in a locked state.
REQ-014 evt_valid  output  1  lock-change event pending.
REQ-015 evt_code  output  1  1 = lock gained, 0 = lock lost; valid only while evt_valid.
REQ-016 evt_ready  input  1  consumer accepts the event.

Function
REQ-017 A sample is accepted on a rising edge only when in_valid and in_ready are both 1.
REQ-018 in_ready is registered and equals NOT evt_valid, so no sample is accepted while an event is pending.
REQ-019 Equality is a==b on all 2 bits; the result of an accepted sample is visible on the counters, run_cnt, lock and evt_* one cycle after acceptance.
REQ-020 An accepted match increments match_cnt and run_cnt; an accepted miss increments miss_cnt and clears run_cnt to 0.
REQ-021 match_cnt and miss_cnt saturate at all-ones, and run_cnt saturates at RUN_LEN; none of them wraps.
REQ-022 FSM states: HUNT, LOCKED, plus LOCKED_WARN when configured (REQ-032).
REQ-023 HUNT->LOCKED when an accepted match brings run_cnt to RUN_LEN; the same edge sets evt_valid=1 and evt_code=1.
REQ-024 LOCKED->HUNT on an accepted miss; the same edge sets evt_valid=1 and evt_code=0.
REQ-025 lock is 1 in LOCKED and LOCKED_WARN, and 0 in HUNT.
REQ-026 evt_valid, once set, holds with evt_code stable until a rising edge with evt_ready=1 clears it; evt_valid=0 with evt_ready=1 has no effect.
REQ-027 clr=1 on an edge zeroes both counters and run_cnt, forces HUNT and clears evt_valid; any concurrently accepted sample is discarded.
REQ-028 With RUN_LEN=1, a single accepted match from HUNT causes lock.

Reset
REQ-029 Assertion of reset immediately forces HUNT, match_cnt=0, miss_cnt=0, run_cnt=0, lock=0, evt_valid=0, evt_code=0 and in_ready=0.
REQ-030 in_ready becomes 1 on the first rising edge after reset deasserts.
REQ-031 Reset during a pending event discards that event.

Configuration
REQ-032 Macro EQ2_MON_HYST_EN defined: in LOCKED, a first accepted miss moves to LOCKED_WARN with lock still 1 and no event.
  - From LOCKED_WARN, a second consecutive miss moves to HUNT and raises the loss event.
  - From LOCKED_WARN, a match returns to LOCKED without an event.
  - Both misses count in miss_cnt, and run_cnt clears on each miss.
REQ-033 Macro EQ2_MON_HYST_EN undefined: LOCKED_WARN does not exist and REQ-024 applies unchanged.

Structure
REQ-034 Package eq2_mon_pkg holds the FSM state enum typedef and the constants EVT_LOCK=1'b1 and EVT_LOSS=1'b0.
REQ-035 The comparison is done by one instance of the existing 2-bit comparator eq2 (ports a, b, aeqb); no other sub-module is used.

Verification
REQ-036 Reset, then 4 matches (a=b=2'b01) with RUN_LEN=4 -> lock=1 and evt_valid=1 with evt_code=1 after the 4th; match_cnt=4.
REQ-037 Lock pending with evt_ready=0 for 3 cycles and in_valid=1 -> in_ready=0, no sample accepted, match_cnt unchanged.
REQ-038 Locked, then one miss (a=2'b11, b=2'b01) -> without the macro: lock=0, evt_code=0, miss_cnt=1; with EQ2_MON_HYST_EN: lock=1, no event, and a second miss -> lock=0 with a loss event.
REQ-039 CNT_W=2, 5 consecutive misses -> miss_cnt holds at 3.
REQ-040 clr=1 together with an accepted match while run_cnt=3 -> all counters 0, HUNT, match_cnt stays 0.
REQ-041 reset asserted mid-run with run_cnt=2 and an event pending -> all outputs are at their reset values before the next clock edge.
